// File: rtl/acc_cpu_core_if.sv
// acc_cpu_core_if: bus bundle between the accumulator core and its
// environment (instruction ROM, data RAM, handshaked I/O ports, debug taps).
//   master : the core (drives addresses, strobes, port outputs, status)
//   slave  : memories / I/O / observer
// Parameters must match the core instance they connect to.
interface acc_cpu_core_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8,
  parameter int OP_BITS   = 4
);
  logic [ADDR_BITS-1:0]         imem_addr;
  logic [OP_BITS+ADDR_BITS-1:0] imem_data;
  logic [ADDR_BITS-1:0]         dmem_addr;
  logic [DATA_BITS-1:0]         dmem_wdata;
  logic                         dmem_we;
  logic [DATA_BITS-1:0]         dmem_rdata;
  logic [DATA_BITS-1:0]         port_in;
  logic                         port_in_valid;
  logic                         port_in_ack;
  logic [DATA_BITS-1:0]         port_out;
  logic                         port_out_valid;
  logic                         carry_out;
  logic                         halted;
  logic [OP_BITS-1:0]           cmd_out;
  logic [ADDR_BITS-1:0]         reg_pc_out;

  modport master (
    output imem_addr, input imem_data,
    output dmem_addr, dmem_wdata, dmem_we, input dmem_rdata,
    input  port_in, port_in_valid, output port_in_ack,
    output port_out, port_out_valid,
    output carry_out, halted, cmd_out, reg_pc_out
  );

  modport slave (
    input  imem_addr, output imem_data,
    input  dmem_addr, dmem_wdata, dmem_we, output dmem_rdata,
    output port_in, port_in_valid, input port_in_ack,
    input  port_out, port_out_valid,
    input  carry_out, halted, cmd_out, reg_pc_out
  );
endinterface

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator processor.
// Each instruction walks FETCH -> DECODE -> MEM -> EXEC (4 cycles); IN may
// stall in EXEC until port_in_valid. HALT parks the core in HALTED until reset.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   bus (master) : imem_addr/imem_data (sync ROM, 1-cycle latency),
//                  dmem_addr/dmem_wdata/dmem_we/dmem_rdata (sync RAM),
//                  port_in/port_in_valid/port_in_ack, port_out/port_out_valid,
//                  carry_out, halted, cmd_out (ir opcode), reg_pc_out (pc)
module acc_cpu_core #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8,
  parameter int OP_BITS   = 4
) (
  input  logic             clock,
  input  logic             reset,
  acc_cpu_core_if.master   bus
);
  localparam int IW = OP_BITS + ADDR_BITS;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALTED
  } state_e;

  localparam logic [OP_BITS-1:0] OP_LOAD = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_STO  = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_SUM  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_SUB  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_MULT = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_DIV  = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_JUMP = OP_BITS'(7);
  localparam logic [OP_BITS-1:0] OP_TST  = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_IN   = OP_BITS'(9);
  localparam logic [OP_BITS-1:0] OP_OUT  = OP_BITS'(10);
  localparam logic [OP_BITS-1:0] OP_LDI  = OP_BITS'(11);
  localparam logic [OP_BITS-1:0] OP_HALT = OP_BITS'(15);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d, daddr_q, daddr_d;
  logic [DATA_BITS-1:0] acc_q, acc_d, pout_q, pout_d, wdata_q, wdata_d;
  logic [IW-1:0]        ir_q, ir_d;
  logic                 carry_q, carry_d, pvld_q, pvld_d;
  logic                 we_c, ack_c;

  logic [OP_BITS-1:0]   op, fetch_op;
  logic [ADDR_BITS-1:0] opa;
  logic [DATA_BITS:0]   sum_w;
  logic [DATA_BITS-1:0] diff_w, prod_w, quo_w;
  logic                 borrow_w, div0_w;

  assign op       = ir_q[IW-1:ADDR_BITS];
  assign opa      = ir_q[ADDR_BITS-1:0];
  assign fetch_op = bus.imem_data[IW-1:ADDR_BITS];

  // Datapath results; all unsigned, selected by the EXEC decode below.
  assign sum_w    = {1'b0, acc_q} + {1'b0, bus.dmem_rdata};
  assign diff_w   = acc_q - bus.dmem_rdata;
  assign borrow_w = acc_q < bus.dmem_rdata;
  assign prod_w   = acc_q * bus.dmem_rdata;
  assign div0_w   = (bus.dmem_rdata == '0);
  assign quo_w    = div0_w ? '1 : (acc_q / bus.dmem_rdata);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    pout_d  = pout_q;
    pvld_d  = 1'b0;
    daddr_d = daddr_q;
    wdata_d = wdata_q;
    we_c    = 1'b0;
    ack_c   = 1'b0;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // Address/store data are registered here so they are stable for the
        // whole MEM cycle and held through EXEC.
        ir_d    = bus.imem_data;
        daddr_d = bus.imem_data[ADDR_BITS-1:0];
        if (fetch_op == OP_STO) wdata_d = acc_q;
        state_d = S_MEM;
      end
      S_MEM: begin
        we_c    = (op == OP_STO);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + ADDR_BITS'(1);
        case (op)
          OP_LOAD: acc_d = bus.dmem_rdata;
          OP_SUM:  {carry_d, acc_d} = sum_w;
          OP_SUB:  begin acc_d = diff_w; carry_d = borrow_w; end
          OP_MULT: acc_d = prod_w;
          OP_DIV:  begin acc_d = quo_w; if (div0_w) carry_d = 1'b1; end
          OP_JUMP: pc_d = opa;
          OP_TST:  if (acc_q == '0) pc_d = pc_q + ADDR_BITS'(2);
          OP_IN: begin
            if (bus.port_in_valid) begin
              acc_d = bus.port_in;
              ack_c = 1'b1;
            end else begin
              state_d = S_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_OUT:  begin pout_d = acc_q; pvld_d = 1'b1; end
          OP_LDI:  acc_d = DATA_BITS'(opa);
          OP_HALT: begin state_d = S_HALTED; pc_d = pc_q; end
          default: ;
        endcase
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
      pout_q  <= '0;
      pvld_q  <= 1'b0;
      daddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      pout_q  <= pout_d;
      pvld_q  <= pvld_d;
      daddr_q <= daddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes are combinational, so reset must mask them: a STO whose MEM
  // cycle coincides with reset would otherwise still write on that edge.
  assign bus.dmem_we        = we_c & ~reset;
  assign bus.port_in_ack    = ack_c & ~reset;
  assign bus.imem_addr      = pc_q;
  assign bus.dmem_addr      = daddr_q;
  assign bus.dmem_wdata     = wdata_q;
  assign bus.port_out       = pout_q;
  assign bus.port_out_valid = pvld_q;
  assign bus.carry_out      = carry_q;
  assign bus.halted         = (state_q == S_HALTED);
  assign bus.cmd_out        = op;
  assign bus.reg_pc_out     = pc_q;
endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;
  localparam int DB = 8, AB = 8, OB = 4, IW = OB + AB;
  localparam int DMASK = (1 << DB) - 1, PCM = 1 << AB;

  typedef struct { int data; int carry; int pc; int cyc; } out_ev_t;
  typedef struct { int addr; int data; int cyc; } wr_ev_t;
  typedef struct { int d; int v; } in_ev_t;

  logic clk = 0, rst = 1, rst16 = 1;
  always #5 clk = ~clk;

  acc_cpu_core_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .OP_BITS(OB)) bus ();
  acc_cpu_core #(.DATA_BITS(DB), .ADDR_BITS(AB), .OP_BITS(OB)) dut (
    .clock(clk), .reset(rst), .bus(bus));

  acc_cpu_core_if #(.DATA_BITS(16), .ADDR_BITS(10), .OP_BITS(4)) b16 ();
  acc_cpu_core #(.DATA_BITS(16), .ADDR_BITS(10), .OP_BITS(4)) dut16 (
    .clock(clk), .reset(rst16), .bus(b16));

  logic [IW-1:0] imem [256];
  logic [DB-1:0] dmem [256];
  logic [DB-1:0] m_dmem [256];
  logic [13:0]   im16 [1024];
  logic [15:0]   dm16 [1024];

  int checks = 0, errors = 0;
  int cyc = 0, cyc16 = 0;
  int acks = 0, exp_acks = 0, exp_halt = 0;
  int in_fix_d = -1, in_fix_v = 0;
  out_ev_t out_q[$], out16_q[$];
  wr_ev_t  wr_q[$];
  in_ev_t  in_q[$];
  out_ev_t mo, mo16;
  wr_ev_t  mw;
  in_ev_t  drv_ie;

  // Synchronous ROM/RAM models (1-cycle read latency)
  always @(posedge clk) begin
    bus.imem_data  <= imem[bus.imem_addr];
    bus.dmem_rdata <= dmem[bus.dmem_addr];
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    b16.imem_data  <= im16[b16.imem_addr];
    b16.dmem_rdata <= dm16[b16.dmem_addr];
    if (b16.dmem_we) dm16[b16.dmem_addr] <= b16.dmem_wdata;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0; else cyc <= cyc + 1;
    if (rst16) cyc16 <= 0; else cyc16 <= cyc16 + 1;
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [IW-1:0] ins(int op, int a);
    return IW'((op << AB) | (a & (PCM - 1)));
  endfunction

  function automatic logic [13:0] ins16(int op, int a);
    return 14'((op << 10) | (a & 1023));
  endfunction

  // ISA-level reference: interprets the program, predicting every store,
  // every OUT (value/carry/pc/cycle), IN stimulus and the halt cycle.
  function automatic void run_model();
    int pc, acc, c, t, tstart, w, op, a, nxt, s, d, v, m;
    bit done;
    pc = 0; acc = 0; c = 0; t = 0; done = 0;
    for (int i = 0; i < 256; i++) m_dmem[i] = dmem[i];
    for (int n = 0; n < 1000 && !done; n++) begin
      w = int'(imem[pc]); op = w >> AB; a = w & (PCM - 1);
      m = int'(m_dmem[a]);
      tstart = t; t += 4; nxt = (pc + 1) % PCM;
      case (op)
        1: acc = m;
        2: begin m_dmem[a] = DB'(acc); wr_q.push_back('{a, acc, tstart + 2}); end
        3: begin s = acc + m; c = (s > DMASK) ? 1 : 0; acc = s & DMASK; end
        4: begin c = (acc < m) ? 1 : 0; acc = (acc - m) & DMASK; end
        5: acc = (acc * m) & DMASK;
        6: if (m == 0) begin acc = DMASK; c = 1; end else acc = acc / m;
        7: nxt = a;
        8: if (acc == 0) nxt = (pc + 2) % PCM;
        9: begin
          d = (in_fix_d >= 0) ? in_fix_d : int'($urandom_range(0, 3));
          v = (in_fix_d >= 0) ? in_fix_v : int'($urandom_range(0, DMASK));
          in_q.push_back('{d, v}); acc = v; t += d; exp_acks++;
        end
        10: out_q.push_back('{acc, c, nxt, t});
        11: acc = a & DMASK;
        15: begin done = 1; nxt = pc; exp_halt = t; end
        default: ;
      endcase
      pc = nxt;
    end
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (bus.port_out_valid) begin
      if (out_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mo = out_q.pop_front();
        chk("out_data", int'(bus.port_out), mo.data);
        chk("out_carry", int'(bus.carry_out), mo.carry);
        chk("out_pc", int'(bus.reg_pc_out), mo.pc);
        chk("out_cycle", cyc, mo.cyc);
      end
    end
    if (bus.dmem_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        mw = wr_q.pop_front();
        chk("wr_addr", int'(bus.dmem_addr), mw.addr);
        chk("wr_data", int'(bus.dmem_wdata), mw.data);
        chk("wr_cycle", cyc, mw.cyc);
      end
    end
    if (bus.port_in_ack) acks++;
    if (b16.port_out_valid) begin
      if (out16_q.size() == 0) chk("unexpected_out16", 1, 0);
      else begin
        mo16 = out16_q.pop_front();
        chk("out16_data", int'(b16.port_out), mo16.data);
        chk("out16_carry", int'(b16.carry_out), mo16.carry);
        chk("out16_pc", int'(b16.reg_pc_out), mo16.pc);
      end
    end
  end

  // Input-port driver: when an IN reaches MEM, hold valid low for the
  // scheduled number of EXEC cycles, then present data for one cycle.
  initial begin
    bus.port_in = '0; bus.port_in_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.cmd_out == 4'd9 && !bus.halted) begin
        if (in_q.size() != 0) drv_ie = in_q.pop_front(); else drv_ie = '{0, 0};
        repeat (drv_ie.d + 1) begin @(posedge clk); #1; end
        bus.port_in = DB'(drv_ie.v); bus.port_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.port_in_valid = 1'b0;
        while (!rst && bus.cmd_out == 4'd9) begin @(posedge clk); #1; end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic check_reset(string nm);
    chk({nm, "_imem_addr"}, int'(bus.imem_addr), 0);
    chk({nm, "_pc"}, int'(bus.reg_pc_out), 0);
    chk({nm, "_cmd"}, int'(bus.cmd_out), 0);
    chk({nm, "_carry"}, int'(bus.carry_out), 0);
    chk({nm, "_port_out"}, int'(bus.port_out), 0);
    chk({nm, "_out_valid"}, int'(bus.port_out_valid), 0);
    chk({nm, "_ack"}, int'(bus.port_in_ack), 0);
    chk({nm, "_we"}, int'(bus.dmem_we), 0);
    chk({nm, "_dmem_addr"}, int'(bus.dmem_addr), 0);
    chk({nm, "_wdata"}, int'(bus.dmem_wdata), 0);
    chk({nm, "_halted"}, int'(bus.halted), 0);
  endtask

  task automatic run_prog(string nm);
    int pc_h, mism;
    out_q.delete(); wr_q.delete(); in_q.delete();
    exp_acks = 0; exp_halt = -1;
    run_model();
    apply_reset();
    acks = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.halted) break;
    end
    chk({nm, "_halted"}, int'(bus.halted), 1);
    chk({nm, "_halt_cycle"}, cyc, exp_halt);
    pc_h = int'(bus.reg_pc_out);
    repeat (6) @(negedge clk);
    chk({nm, "_pc_frozen"}, int'(bus.reg_pc_out), pc_h);
    chk({nm, "_outs_left"}, out_q.size(), 0);
    chk({nm, "_writes_left"}, wr_q.size(), 0);
    chk({nm, "_acks"}, acks, exp_acks);
    mism = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] != m_dmem[i]) mism++;
    chk({nm, "_dmem"}, mism, 0);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = ins(15, 0);
  endtask

  task automatic gen_random();
    int len, r, op, a;
    bit prev_in;
    clear_imem();
    for (int i = 0; i < 256; i++)
      dmem[i] = ($urandom_range(0, 7) == 0) ? '0 : DB'($urandom);
    len = int'($urandom_range(10, 30));
    prev_in = 0;
    for (int i = 0; i < len - 1; i++) begin
      r = int'($urandom_range(0, 99));
      a = int'($urandom_range(0, PCM - 1));
      if      (r < 10) op = 1;
      else if (r < 18) op = 2;
      else if (r < 30) op = 3;
      else if (r < 40) op = 4;
      else if (r < 47) op = 5;
      else if (r < 53) op = 6;
      else if (r < 58) op = 7;
      else if (r < 65) op = 8;
      else if (r < 72) op = 9;
      else if (r < 87) op = 10;
      else if (r < 95) op = 11;
      else op = (r < 97) ? 0 : 12 + (r % 3);
      if (prev_in && op == 9) op = 10;
      if (op >= 1 && op <= 6) a = 8'h80 + int'($urandom_range(0, 15));
      if (op == 7) begin
        a = i + 1 + int'($urandom_range(0, 5));
        if (a > len - 1) a = len - 1;
      end
      imem[i] = ins(op, a);
      prev_in = (op == 9);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin im16[i] = ins16(15, 0); dm16[i] = '0; end
    b16.port_in = '0; b16.port_in_valid = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset state
    clear_imem();
    apply_reset();
    @(negedge clk);
    check_reset("rst0");

    // LDI/STO/LOAD/SUM/OUT/HALT
    clear_imem();
    imem[0] = ins(11, 5); imem[1] = ins(2, 8'h10); imem[2] = ins(1, 8'h10);
    imem[3] = ins(3, 8'h10); imem[4] = ins(10, 0); imem[5] = ins(15, 0);
    run_prog("basic");
    chk("basic_halt_at_24", cyc - 6, 24);
    chk("basic_port_out", int'(bus.port_out), 10);
    chk("basic_mem10", int'(dmem[8'h10]), 5);

    // ALU corner cases
    clear_imem();
    dmem[8'h40] = 100; dmem[8'h41] = 50; dmem[8'h42] = 16; dmem[8'h43] = 0;
    imem[0]  = ins(11, 200);    imem[1]  = ins(3, 8'h40); imem[2]  = ins(10, 0);
    imem[3]  = ins(4, 8'h41);   imem[4]  = ins(10, 0);    imem[5]  = ins(11, 16);
    imem[6]  = ins(5, 8'h42);   imem[7]  = ins(10, 0);    imem[8]  = ins(11, 7);
    imem[9]  = ins(6, 8'h43);   imem[10] = ins(10, 0);    imem[11] = ins(4, 8'h41);
    imem[12] = ins(10, 0);      imem[13] = ins(6, 8'h43); imem[14] = ins(10, 0);
    imem[15] = ins(15, 0);
    run_prog("alu");

    // Reset while HALTED
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_reset("rst_halted");

    // TST / JUMP / PC wrap
    clear_imem();
    imem[8'h00] = ins(7, 8'h20); imem[8'h01] = ins(10, 0);    imem[8'h02] = ins(15, 0);
    imem[8'h20] = ins(8, 0);     imem[8'h21] = ins(11, 8'h77); imem[8'h22] = ins(10, 0);
    imem[8'h23] = ins(11, 3);    imem[8'h24] = ins(8, 0);     imem[8'h25] = ins(10, 0);
    imem[8'h26] = ins(11, 0);    imem[8'h27] = ins(7, 8'hFF); imem[8'hFF] = ins(8, 0);
    run_prog("tst_jump");

    // IN with 5-cycle stall
    clear_imem();
    imem[0] = ins(9, 0); imem[1] = ins(10, 0); imem[2] = ins(15, 0);
    in_fix_d = 5; in_fix_v = 8'hA5;
    run_prog("in_stall");
    in_fix_d = -1;
    chk("in_port_out", int'(bus.port_out), 8'hA5);

    // Reset during MEM of STO: the store must not happen
    clear_imem();
    imem[0] = ins(11, 9); imem[1] = ins(2, 8'h30); imem[2] = ins(15, 0);
    dmem[8'h30] = 8'h5A;
    out_q.delete(); wr_q.delete(); in_q.delete();
    apply_reset();
    for (int i = 0; i < 50 && cyc != 6; i++) begin @(posedge clk); #1; end
    chk("sto_abort_reached_mem", cyc, 6);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_reset("rst_sto");
    chk("sto_abort_mem30", int'(dmem[8'h30]), 8'h5A);
    run_prog("sto_after_reset");

    // Randomized programs
    for (int k = 0; k < 15; k++) begin
      gen_random();
      run_prog($sformatf("rand%0d", k));
    end

    // DATA_BITS=16 / ADDR_BITS=10 instance: zero-extend, carry, PC wrap
    dm16[0] = 16'hFC01;
    im16[10'h000] = ins16(8, 0);      im16[10'h001] = ins16(15, 0);
    im16[10'h002] = ins16(7, 10'h3FB);
    im16[10'h3FB] = ins16(11, 10'h3FF); im16[10'h3FC] = ins16(3, 0);
    im16[10'h3FD] = ins16(10, 0);     im16[10'h3FE] = ins16(11, 7);
    im16[10'h3FF] = ins16(10, 0);
    out16_q.push_back('{16'h0000, 1, 10'h3FE, 0});
    out16_q.push_back('{16'h0007, 1, 10'h000, 0});
    @(posedge clk); #1 rst16 = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (b16.halted) break;
    end
    chk("p16_halted", int'(b16.halted), 1);
    chk("p16_halt_cycle", cyc16, 36);
    chk("p16_pc", int'(b16.reg_pc_out), 1);
    chk("p16_outs_left", out16_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
